divider_block: RTL and testbench



---
 rtl/softmax_pkg.sv | 32 +++
 rtl/divider_block_if.sv | 39 +++
 rtl/serial_divider.sv | 94 +++++++++
 rtl/divider_block.sv | 130 +++++++++++++
 tb/tb_divider_block.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
// Shared types and sizing helpers for the softmax normalisation datapath.
package softmax_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitSum,
        StDivide,
        StOutput,
        StDone
    } div_state_e;

    localparam int unsigned DefaultDataSize     = 32;
    localparam int unsigned DefaultNumberOfData = 10;
    localparam int unsigned DefaultFracBits     = 16;
    localparam int unsigned MaxDataSize         = 64;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned ds, input int unsigned fb);
        return int'($clog2(ds + fb + 1));
    endfunction

    localparam int unsigned PtrWidth = ptr_width(DefaultNumberOfData);
    localparam int unsigned CntWidth = cnt_width(DefaultDataSize, DefaultFracBits);

    // Sliced down to data_size bits wherever a saturated result is produced.
    localparam logic [MaxDataSize-1:0] SatAllOnes = '1;

endpackage

// File: rtl/divider_block_if.sv
// Stream/handshake bundle between the exponent accumulator, divider_block and its consumer.
interface divider_block_if #(
    parameter int unsigned data_size = 32
);
    logic [data_size-1:0] divider_data_i;
    logic                 divider_data_valid_i;
    logic [data_size-1:0] sum_i;
    logic                 sum_valid_i;
    logic                 divider_data_ready_i;
    logic [data_size-1:0] divider_data_o;
    logic                 divider_data_valid_o;
    logic                 divider_busy_o;
    logic                 divider_done_o;

    modport slave (
        input  divider_data_i,
        input  divider_data_valid_i,
        input  sum_i,
        input  sum_valid_i,
        input  divider_data_ready_i,
        output divider_data_o,
        output divider_data_valid_o,
        output divider_busy_o,
        output divider_done_o
    );

    modport master (
        output divider_data_i,
        output divider_data_valid_i,
        output sum_i,
        output sum_valid_i,
        output divider_data_ready_i,
        input  divider_data_o,
        input  divider_data_valid_o,
        input  divider_busy_o,
        input  divider_done_o
    );

endinterface

// File: rtl/serial_divider.sv
// Bit-serial restoring divider: (exp << frac_bits) / divisor, saturating at all ones.
// DIVIDER_ROUND_EN adds one iteration and rounds the quotient half-up.
module serial_divider
    import softmax_pkg::*;
#(
    parameter int unsigned data_size = DefaultDataSize,
    parameter int unsigned frac_bits = DefaultFracBits
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [data_size-1:0] exp_i,
    input  logic [data_size-1:0] divisor_i,
    output logic                 done_o,
    output logic [data_size-1:0] result_o
);

`ifdef DIVIDER_ROUND_EN
    localparam int unsigned RoundBits = 1;
`else
    localparam int unsigned RoundBits = 0;
`endif
    localparam int unsigned QuotWidth = data_size + frac_bits + RoundBits;
    localparam int unsigned CntW      = cnt_width(data_size, frac_bits + RoundBits);

    logic [QuotWidth-1:0] quot_q, quot_next, dividend_init;
    logic [data_size-1:0] rem_q, rem_d, divisor_q;
    logic [data_size:0]   rem_shift;
    logic                 sub_ok, div_zero_q, busy_q;
    logic [CntW-1:0]      cnt_q;

    // Dividend and quotient share one shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        dividend_init = '0;
        dividend_init[QuotWidth-1 -: data_size] = exp_i;
        rem_shift = {rem_q, quot_q[QuotWidth-1]};
        sub_ok    = rem_shift >= {1'b0, divisor_q};
        // True difference is below the divisor, so the low bits are exact.
        rem_d     = sub_ok ? (rem_shift[data_size-1:0] - divisor_q) : rem_shift[data_size-1:0];
        quot_next = {quot_q[QuotWidth-2:0], sub_ok};
    end

`ifdef DIVIDER_ROUND_EN
    logic [QuotWidth-2:0] int_part;
    logic [data_size:0]   rounded;

    always_comb begin
        int_part = quot_next[QuotWidth-1:1];
        rounded  = {1'b0, int_part[data_size-1:0]} + {{data_size{1'b0}}, quot_next[0]};
        if (div_zero_q || (|int_part[QuotWidth-2:data_size]) || rounded[data_size]) begin
            result_o = SatAllOnes[data_size-1:0];
        end else begin
            result_o = rounded[data_size-1:0];
        end
    end
`else
    always_comb begin
        if (div_zero_q || (|quot_next[QuotWidth-1:data_size])) begin
            result_o = SatAllOnes[data_size-1:0];
        end else begin
            result_o = quot_next[data_size-1:0];
        end
    end
`endif

    assign done_o = busy_q && (cnt_q == CntW'(1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            div_zero_q <= 1'b0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            cnt_q      <= CntW'(QuotWidth);
            quot_q     <= dividend_init;
            rem_q      <= '0;
            divisor_q  <= divisor_i;
            div_zero_q <= (divisor_i == '0);
        end else if (busy_q) begin
            quot_q <= quot_next;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/divider_block.sv
// Softmax normalisation: buffers a vector of exponents, latches their sum and emits
// exp/sum quotients in order. Rounding is selected by DIVIDER_ROUND_EN in serial_divider.
module divider_block
    import softmax_pkg::*;
#(
    parameter int unsigned data_size      = DefaultDataSize,
    parameter int unsigned number_of_data = DefaultNumberOfData,
    parameter int unsigned frac_bits      = DefaultFracBits
) (
    input logic            clock_i,
    input logic            reset_i,
    divider_block_if.slave bus
);

    localparam int unsigned     PtrW     = ptr_width(number_of_data);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(number_of_data - 1);

    div_state_e           state_q, state_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [data_size-1:0] mem_q [number_of_data];
    logic [data_size-1:0] sum_q, data_q, div_result;
    logic                 sum_latched_q, mem_we, div_start, div_done;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_we    = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            // IDLE and LOAD share the write path; IDLE always starts at slot 0.
            StIdle, StLoad: begin
                if (bus.divider_data_valid_i) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LastSlot) begin
                        if (sum_latched_q) begin
                            state_d   = StDivide;
                            div_start = 1'b1;
                        end else begin
                            state_d = StWaitSum;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        state_d  = StLoad;
                    end
                end
            end
            StWaitSum: begin
                if (sum_latched_q) begin
                    state_d   = StDivide;
                    div_start = 1'b1;
                end
            end
            StDivide: begin
                if (div_done) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (bus.divider_data_ready_i) begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    if (rd_ptr_q == LastSlot) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StDivide;
                        div_start = 1'b1;
                    end
                end
            end
            StDone: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            sum_latched_q <= 1'b0;
            sum_q         <= '0;
            data_q        <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (state_q == StDone) begin
                sum_latched_q <= 1'b0;
            end else if ((state_q == StLoad || state_q == StWaitSum) &&
                         bus.sum_valid_i && !sum_latched_q) begin
                sum_q         <= bus.sum_i;
                sum_latched_q <= 1'b1;
            end
            if (state_q == StDivide && div_done) begin
                data_q <= div_result;
            end
        end
    end

    // Vector storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.divider_data_i;
        end
    end

    // Operand is selected with the next read pointer so a division can start on the handshake.
    serial_divider #(
        .data_size (data_size),
        .frac_bits (frac_bits)
    ) u_serial_divider (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .start_i   (div_start),
        .exp_i     (mem_q[rd_ptr_d]),
        .divisor_i (sum_q),
        .done_o    (div_done),
        .result_o  (div_result)
    );

    assign bus.divider_data_o       = data_q;
    assign bus.divider_data_valid_o = (state_q == StOutput);
    assign bus.divider_busy_o       = (state_q != StIdle);
    assign bus.divider_done_o       = (state_q == StDone);

endmodule

// File: tb/tb_divider_block.sv
// Directed bench for divider_block with a 4-element vector; expectations follow
// DIVIDER_ROUND_EN when it is defined for the build.
module tb_divider_block;

    localparam int unsigned DataSize = 32;
    localparam int unsigned NumData  = 4;
    localparam int unsigned FracBits = 16;
`ifdef DIVIDER_ROUND_EN
    localparam int DivGap = 50;
`else
    localparam int DivGap = 49;
`endif
    localparam int WaitLimit = 300;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    divider_block_if #(.data_size(DataSize)) bus ();

    divider_block #(
        .data_size      (DataSize),
        .number_of_data (NumData),
        .frac_bits      (FracBits)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load4(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] v [4];
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        for (int i = 0; i < 4; i++) begin
            bus.divider_data_i       = v[i];
            bus.divider_data_valid_i = 1'b1;
            step();
        end
        bus.divider_data_valid_i = 1'b0;
    endtask

    // n = index of the first cycle (1 = the current one) with valid high.
    task automatic wait_valid(output int n);
        n = 1;
        while (bus.divider_data_valid_o !== 1'b1 && n < WaitLimit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.divider_data_o !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h want=0", bus.divider_data_o);
        end
        checks++;
        if (bus.divider_data_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", bus.divider_data_valid_o);
        end
        checks++;
        if (bus.divider_busy_o !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", bus.divider_busy_o);
        end
        checks++;
        if (bus.divider_done_o !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b want=0", bus.divider_done_o);
        end
        reset = 1'b0;
        bus.sum_valid_i = 1'b1;
        step();
        checks++;
        if (bus.divider_busy_o !== 1'b0) begin
            failures++; $display("FAIL idle_ignores_sum busy got=%b want=0", bus.divider_busy_o);
        end
    endtask

    task automatic test_basic();
        int n;
        bus.sum_i = 32'd4;
        bus.sum_valid_i = 1'b1;
        bus.divider_data_ready_i = 1'b1;
        load4(32'd1, 32'd1, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            checks++;
            if (n !== DivGap) begin
                failures++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, n, DivGap);
            end
            checks++;
            if (bus.divider_data_o !== 32'h0000_4000) begin
                failures++;
                $display("FAIL basic_data[%0d] got=%h want=00004000", i, bus.divider_data_o);
            end
            step();
        end
        checks++;
        if (bus.divider_done_o !== 1'b1 || bus.divider_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got done=%b busy=%b want done=1 busy=1",
                     bus.divider_done_o, bus.divider_busy_o);
        end
        step();
        checks++;
        if (bus.divider_done_o !== 1'b0 || bus.divider_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_after_done got done=%b busy=%b want done=0 busy=0",
                     bus.divider_done_o, bus.divider_busy_o);
        end
    endtask

    task automatic test_rounding();
        int n;
        logic [31:0] want [4];
`ifdef DIVIDER_ROUND_EN
        want = '{32'h0000_AAAB, 32'h0000_5555, 32'h0000_0000, 32'h0001_0000};
`else
        want = '{32'h0000_AAAA, 32'h0000_5555, 32'h0000_0000, 32'h0001_0000};
`endif
        bus.sum_i = 32'd3;
        load4(32'd2, 32'd1, 32'd0, 32'd3);
        // A fifth element beyond the vector length must be dropped.
        bus.divider_data_i = 32'hDEAD_BEEF;
        bus.divider_data_valid_i = 1'b1;
        step();
        bus.divider_data_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            checks++;
            if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== want[i]) begin
                failures++;
                $display("FAIL round_data[%0d] got=%h valid=%b want=%h", i,
                         bus.divider_data_o, bus.divider_data_valid_o, want[i]);
            end
            step();
        end
        step();
        step();
        checks++;
        if (bus.divider_busy_o !== 1'b0 || bus.divider_data_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL round_extra_ignored got busy=%b valid=%b want 0 0",
                     bus.divider_busy_o, bus.divider_data_valid_o);
        end
    endtask

    task automatic test_late_sum();
        int n;
        bit bad;
        logic [31:0] want [4];
        want = '{32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000};
        bus.sum_valid_i = 1'b0;
        bus.sum_i = 32'd6;
        load4(32'd3, 32'd6, 32'd9, 32'd12);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.divider_data_valid_o !== 1'b0 || bus.divider_busy_o !== 1'b1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL late_sum_wait got=early_activity want=idle_wait");
        end
        bus.sum_valid_i = 1'b1;
        step();
        bus.sum_i = 32'd1;
        wait_valid(n);
        checks++;
        if (n !== DivGap + 1) begin
            failures++; $display("FAIL late_sum_latency got=%0d want=%0d", n, DivGap + 1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_valid(n);
            checks++;
            if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== want[i]) begin
                failures++;
                $display("FAIL late_sum_data[%0d] got=%h want=%h", i, bus.divider_data_o, want[i]);
            end
            bus.sum_i = 32'd7 + 32'(i);
            step();
        end
        step();
    endtask

    task automatic test_back_pressure();
        int n;
        bit bad;
        logic [31:0] held;
        bus.sum_i = 32'd5;
        load4(32'd5, 32'd10, 32'd15, 32'd20);
        wait_valid(n);
        checks++;
        if (bus.divider_data_o !== 32'h0001_0000) begin
            failures++; $display("FAIL bp_data[0] got=%h want=00010000", bus.divider_data_o);
        end
        step();
        bus.divider_data_ready_i = 1'b0;
        wait_valid(n);
        checks++;
        if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== 32'h0002_0000) begin
            failures++; $display("FAIL bp_data[1] got=%h want=00020000", bus.divider_data_o);
        end
        held = bus.divider_data_o;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== held) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL bp_hold got=output_changed want=held_%h", held);
        end
        bus.divider_data_ready_i = 1'b1;
        step();
        wait_valid(n);
        checks++;
        if (n !== DivGap) begin
            failures++; $display("FAIL bp_restart_latency got=%0d want=%0d", n, DivGap);
        end
        checks++;
        if (bus.divider_data_o !== 32'h0003_0000) begin
            failures++; $display("FAIL bp_data[2] got=%h want=00030000", bus.divider_data_o);
        end
        step();
        wait_valid(n);
        checks++;
        if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== 32'h0004_0000) begin
            failures++; $display("FAIL bp_data[3] got=%h want=00040000", bus.divider_data_o);
        end
        step();
        checks++;
        if (bus.divider_done_o !== 1'b1) begin
            failures++; $display("FAIL bp_done got=%b want=1", bus.divider_done_o);
        end
        step();
    endtask

    task automatic test_edge_arith();
        int n;
        logic [31:0] want [4];
        bus.sum_i = 32'd0;
        load4(32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            checks++;
            if (n !== DivGap || bus.divider_data_o !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL div_zero[%0d] got=%h after %0d want=ffffffff after %0d", i,
                         bus.divider_data_o, n, DivGap);
            end
            step();
        end
        step();
        want = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0001_0000};
        bus.sum_i = 32'd1;
        load4(32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            checks++;
            if (bus.divider_data_valid_o !== 1'b1 || bus.divider_data_o !== want[i]) begin
                failures++;
                $display("FAIL saturate[%0d] got=%h want=%h", i, bus.divider_data_o, want[i]);
            end
            step();
        end
        step();
    endtask

    task automatic test_reset_mid_divide();
        int n;
        logic [31:0] want [4];
        bus.sum_i = 32'd2;
        load4(32'h100, 32'h200, 32'h300, 32'h400);
        wait_valid(n);
        checks++;
        if (bus.divider_data_o !== 32'h0080_0000) begin
            failures++; $display("FAIL mid_first got=%h want=00800000", bus.divider_data_o);
        end
        step();
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        checks++;
        if (bus.divider_data_o !== 32'h0 || bus.divider_data_valid_o !== 1'b0 ||
            bus.divider_busy_o !== 1'b0 || bus.divider_done_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got data=%h valid=%b busy=%b done=%b want all 0",
                     bus.divider_data_o, bus.divider_data_valid_o, bus.divider_busy_o,
                     bus.divider_done_o);
        end
        reset = 1'b0;
        want = '{32'h0004_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000};
        load4(32'd8, 32'd4, 32'd2, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            checks++;
            if (n !== DivGap || bus.divider_data_o !== want[i]) begin
                failures++;
                $display("FAIL post_reset[%0d] got=%h after %0d want=%h after %0d", i,
                         bus.divider_data_o, n, want[i], DivGap);
            end
            step();
        end
        checks++;
        if (bus.divider_done_o !== 1'b1) begin
            failures++; $display("FAIL post_reset_done got=%b want=1", bus.divider_done_o);
        end
        step();
    endtask

    initial begin
        bus.divider_data_i       = '0;
        bus.divider_data_valid_i = 1'b0;
        bus.sum_i                = '0;
        bus.sum_valid_i          = 1'b0;
        bus.divider_data_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_late_sum();
        test_back_pressure();
        test_edge_arith();
        test_reset_mid_divide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
